dtu_serializer_array: RTL
=========================

# dtu_serializer_array

Parametrised multi-lane output serializer for the LiTE-DTU data path, the successor to the fixed 4×32-bit serializer. It takes N_LANES parallel words from the 160 MHz datapath and shifts them out one bit per cycle on the serializer clock. Compared with the fixed serializer, it adds:
- a training-pattern mode;
- idle-word insertion when upstream has no data;
- per-lane enable and selectable bit order;
- a consumed-word counter.

## Interface
Parameters:
- N_LANES, 4, number of serial output lanes
- WORD_BITS, 32, bits per word (≥4, power of two); counter width CW = log2(WORD_BITS)
- TRAIN_PATTERN, 32'hA5A5_5A5A, word sent on every enabled lane in training mode (WORD_BITS wide)
- IDLE_PATTERN, 32'hEAAA_AAAA, word sent when no valid data is offered (WORD_BITS wide)

Ports:
- clock  in  1  serializer clock. One clock, all flops on its rising edge.
- rst_b  in  1  reset. Asynchronous and active-low.
- DataIn  in  N_LANES*WORD_BITS  lane i occupies bits [i*WORD_BITS +: WORD_BITS]
- data_valid  in  1  DataIn holds a new word set
- train_mode  in  1  send TRAIN_PATTERN instead of data
- lsb_first  in  1  0 = MSB first, 1 = LSB first
- lane_enable  in  N_LANES  per-lane enable; a disabled lane outputs constant 0
- DataOut  out  N_LANES  serial bit per lane, registered
- handshake  out  1  one-cycle pulse: DataIn word set has been consumed
- frame_start  out  1  high during the first bit of every word
- word_count  out  16  number of data words consumed, wraps
- idle_count  out  8  number of idle words inserted, saturates at 255

## Operation
- Bit counter `cnt` (CW bits) increments every cycle and wraps from WORD_BITS-1 to 0.
- A load edge is the rising edge at which `cnt == WORD_BITS-1`. Only at a load edge are the following sampled: data_valid, train_mode, lsb_first, lane_enable, DataIn. Changes at any other time have no effect on the word in flight.
- At a load edge, the source word is chosen with this priority:
  1. train_mode=1: TRAIN_PATTERN. No handshake; word_count and idle_count unchanged.
  2. data_valid=1: DataIn lane slice. handshake is set; word_count += 1 (wraps 16'hFFFF→0).
  3. Otherwise: IDLE_PATTERN. No handshake; idle_count += 1, saturating at 255.
- A lane with lane_enable[i]=0 at the load edge loads all-zeros, regardless of source.
- Per-word state is latched at the load edge: the bit-order flag `ord` and the shift registers `sh[i]` (WORD_BITS wide).
- Shifting:
  - ord=0: DataOut[i] <= sh[i][WORD_BITS-1] at the load edge; then sh shifts left, bit k is output at cnt=k.
  - ord=1: the mirror image, LSB first.
  - Implementation: DataOut[i] is the registered bit selected from the next shift-register value.
- frame_start is registered; it is high exactly during the cycles with cnt=0.

## Timing
- Reset values (asynchronous, immediate on rst_b=0):
  - cnt=0, sh=0, ord=0;
  - DataOut=0, handshake=0, frame_start=0;
  - word_count=0, idle_count=0.
- After rst_b rises, the first load edge is the WORD_BITS-th rising edge. DataOut stays 0 until then; no handshake precedes it.
- Per-word cycle-level behaviour:
  - Word period is WORD_BITS cycles; the load-to-first-bit latency is 0 cycles after the load edge.
  - Bit j of the word (in send order) is on DataOut during cnt=j.
  - handshake and frame_start are both high during the cnt=0 cycle following a data load.
- Upstream contract:
  - Upstream gets WORD_BITS-1 cycles after the handshake pulse to present the next DataIn/data_valid.
  - data_valid held high with no new data means the same word is resent and counted again; the block does not detect duplicates.
- Reset asserted mid-word: the word is aborted, all state clears, and no partial handshake is issued.
- train_mode falling mid-word: the training word completes; data resumes at the next load edge.

## Test plan
- Reset/startup:
  - Stimulus: defaults, data_valid=1, lane0 word 32'h8000_0001, all lanes enabled; release rst_b.
  - Required: DataOut=0 for 32 cycles. The first load happens at edge 32. Lane0 then outputs 1, thirty 0s, 1. handshake pulses once, in the same cycle as frame_start. word_count=1.
- Bit order:
  - Stimulus: lane1 word 32'h0000_000F with lsb_first=1.
  - Required: lane1 outputs 1,1,1,1 then 28 zeros. With lsb_first=0, it outputs 28 zeros then 1,1,1,1. Toggling lsb_first mid-word does not alter the current word.
- Idle insertion:
  - Stimulus: data_valid=0 for 3 load edges.
  - Required: each enabled lane sends IDLE_PATTERN (32'hEAAA_AAAA) 3 times. No handshake. idle_count=3, word_count unchanged. Over 300 idle words, idle_count saturates at 255.
- Training:
  - Stimulus: train_mode=1 with data_valid=1.
  - Required: every enabled lane sends 32'hA5A5_5A5A. No handshake, counters frozen. Clearing train_mode mid-word, the data word appears only after the current word ends.
- Lane enable:
  - Stimulus: lane_enable=4'b1010 with distinct words on all lanes.
  - Required: lanes 0 and 2 are constant 0; lanes 1 and 3 carry their data; handshake still pulses.
- Async reset mid-word and word_count wrap:
  - Mid-word reset: assert rst_b=0 at cnt=13. Required: all outputs 0 immediately; after release, the next load is WORD_BITS edges later.
  - Wrap: with N_LANES=2, WORD_BITS=16, feed 65537 data words. Required: word_count=1.

Source files
------------

// File: rtl/dtu_serializer_array.sv
// Multi-lane word serializer: parallel words are loaded every WORD_BITS cycles
// and shifted out one bit per cycle per lane, with training, idle fill and lane gating.
module dtu_serializer_array #(
    parameter int                   N_LANES       = 4,
    parameter int                   WORD_BITS     = 32,
    parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = 32'hA5A5_5A5A,
    parameter logic [WORD_BITS-1:0] IDLE_PATTERN  = 32'hEAAA_AAAA
) (
    input  logic                           clock,
    input  logic                           rst_b,
    input  logic [N_LANES*WORD_BITS-1:0]   DataIn,
    input  logic                           data_valid,
    input  logic                           train_mode,
    input  logic                           lsb_first,
    input  logic [N_LANES-1:0]             lane_enable,
    output logic [N_LANES-1:0]             DataOut,
    output logic                           handshake,
    output logic                           frame_start,
    output logic [15:0]                    word_count,
    output logic [7:0]                     idle_count
);

    localparam int CW = $clog2(WORD_BITS);
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    logic [CW-1:0]        cnt;
    logic                 ord;
    logic                 ord_next;
    logic                 load;
    logic                 take_data;
    logic                 take_idle;
    logic [WORD_BITS-1:0] src      [N_LANES];
    logic [WORD_BITS-1:0] sh       [N_LANES];
    logic [WORD_BITS-1:0] sh_next  [N_LANES];
    logic [N_LANES-1:0]   bit_next;

    // Inputs only matter on the load edge; everything else runs off the latched word.
    always_comb begin
        load      = (cnt == LAST);
        take_data = load && !train_mode && data_valid;
        take_idle = load && !train_mode && !data_valid;
        ord_next  = load ? lsb_first : ord;
        bit_next  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (train_mode)
                src[i] = TRAIN_PATTERN;
            else if (data_valid)
                src[i] = DataIn[i*WORD_BITS +: WORD_BITS];
            else
                src[i] = IDLE_PATTERN;

            if (load)
                sh_next[i] = lane_enable[i] ? src[i] : '0;
            else if (ord)
                sh_next[i] = sh[i] >> 1;
            else
                sh_next[i] = sh[i] << 1;

            // The output bit is taken from the value the shifter is about to hold,
            // so the first bit of a word appears right after its load edge.
            bit_next[i] = ord_next ? sh_next[i][0] : sh_next[i][WORD_BITS-1];
        end
    end

    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            cnt         <= '0;
            ord         <= 1'b0;
            DataOut     <= '0;
            handshake   <= 1'b0;
            frame_start <= 1'b0;
            word_count  <= '0;
            idle_count  <= '0;
            for (int i = 0; i < N_LANES; i++) sh[i] <= '0;
        end else begin
            cnt         <= cnt + CW'(1);
            ord         <= ord_next;
            DataOut     <= bit_next;
            handshake   <= take_data;
            frame_start <= load;
            for (int i = 0; i < N_LANES; i++) sh[i] <= sh_next[i];
            if (take_data)
                word_count <= word_count + 16'd1;
            if (take_idle && idle_count != 8'hFF)
                idle_count <= idle_count + 8'd1;
        end
    end

endmodule
